// File: rtl/usr_param.sv
// usr_param: parametrised universal shift register with an autonomous
// burst engine. Eight registered operations (hold, shift, load, rotate,
// arithmetic shift, clear) plus a start/busy/done handshake that repeats a
// shift/rotate operation a programmable number of times.
module usr_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic [2:0]       mode_i,
  input  logic             sin_msb_i,
  input  logic             sin_lsb_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             burst_start_i,
  input  logic [CNT_W-1:0] burst_len_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             sout_msb_o,
  output logic             sout_lsb_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       bmode_q, bmode_d;
  logic             done_q, done_d;

  // Next register value for a given operation code.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] q,
    input logic             smsb,
    input logic             slsb,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] r;
    case (op)
      M_HOLD:  r = q;
      M_SHR:   r = {smsb, q[WIDTH-1:1]};
      M_SHL:   r = {q[WIDTH-2:0], slsb};
      M_LOAD:  r = din;
      M_ROR:   r = {q[0], q[WIDTH-1:1]};
      M_ROL:   r = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ASR:   r = {q[WIDTH-1], q[WIDTH-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Only genuine shift/rotate codes may be repeated by the burst engine;
  // hold, load and clear are idempotent so a burst of them degenerates.
  function automatic logic burstable(input logic [2:0] op);
    return (op == M_SHR) || (op == M_SHL) || (op == M_ROR) ||
           (op == M_ROL) || (op == M_ASR);
  endfunction

  // Next-state: datapath operation, burst counter and handshake decode.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    bmode_d = bmode_q;
    done_d  = 1'b0;
    if (enable_i) begin
      case (state_q)
        ST_IDLE: begin
          data_d = apply_op(mode_i, data_q, sin_msb_i, sin_lsb_i, data_in_i);
          if (burst_start_i) begin
            if ((burst_len_i != '0) && burstable(mode_i)) begin
              // The start edge itself performs the first operation.
              bmode_d = mode_i;
              count_d = burst_len_i - 1'b1;
              if (burst_len_i == CNT_W'(1)) begin
                done_d = 1'b1;
              end else begin
                state_d = ST_BURST;
              end
            end else begin
              done_d = 1'b1;
            end
          end
        end
        default: begin
          data_d  = apply_op(bmode_q, data_q, sin_msb_i, sin_lsb_i, data_in_i);
          count_d = count_q - 1'b1;
          if (count_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
      bmode_q <= M_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      bmode_q <= bmode_d;
      done_q  <= done_d;
    end
  end

  assign data_out_o = data_q;
  assign sout_msb_o = data_q[WIDTH-1];
  assign sout_lsb_o = data_q[0];
  assign busy_o     = (state_q == ST_BURST);
  assign done_o     = done_q;

endmodule

// File: tb/tb_usr_param.sv
// Directed bench for usr_param at WIDTH=4, CNT_W=4.
module tb_usr_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [2:0] mode;
  logic       sin_msb;
  logic       sin_lsb;
  logic [3:0] data_in;
  logic       burst_start;
  logic [3:0] burst_len;
  logic [3:0] dout;
  logic       sout_msb;
  logic       sout_lsb;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  usr_param #(.WIDTH(4), .CNT_W(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .mode_i       (mode),
    .sin_msb_i    (sin_msb),
    .sin_lsb_i    (sin_lsb),
    .data_in_i    (data_in),
    .burst_start_i(burst_start),
    .burst_len_i  (burst_len),
    .data_out_o   (dout),
    .sout_msb_o   (sout_msb),
    .sout_lsb_o   (sout_lsb),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; mode = 3'b000; sin_msb = 1'b0; sin_lsb = 1'b0;
    data_in = 4'b0000; burst_start = 1'b0; burst_len = 4'd0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({dout, busy, done} !== {4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset dout/busy/done got %b/%b/%b want 0000/0/0", dout, busy, done);
    end
    $display("reset: dout=%b busy=%b done=%b", dout, busy, done);
  endtask

  task automatic test_shr();
    enable = 1'b1; mode = 3'b001; sin_msb = 1'b1;
    step();
    checks++;
    if (dout !== 4'b1000) begin
      errors++; $display("FAIL shr1 got %b want 1000", dout);
    end
    step();
    checks++;
    if ({dout, sout_msb, sout_lsb} !== {4'b1100, 1'b1, 1'b0}) begin
      errors++; $display("FAIL shr2 dout/smsb/slsb got %b/%b/%b want 1100/1/0", dout, sout_msb, sout_lsb);
    end
    $display("shr: dout=%b", dout);
  endtask

  task automatic test_shl();
    mode = 3'b111;
    step();
    checks++;
    if (dout !== 4'b0000) begin
      errors++; $display("FAIL clr got %b want 0000", dout);
    end
    mode = 3'b010; sin_lsb = 1'b1; sin_msb = 1'b0;
    step();
    checks++;
    if (dout !== 4'b0001) begin
      errors++; $display("FAIL shl1 got %b want 0001", dout);
    end
    step();
    checks++;
    if ({dout, sout_lsb} !== {4'b0011, 1'b1}) begin
      errors++; $display("FAIL shl2 dout/slsb got %b/%b want 0011/1", dout, sout_lsb);
    end
    $display("shl: dout=%b", dout);
  endtask

  task automatic test_rotate_asr();
    mode = 3'b011; data_in = 4'b1010;
    step();
    checks++;
    if (dout !== 4'b1010) begin
      errors++; $display("FAIL load got %b want 1010", dout);
    end
    mode = 3'b100;
    step();
    checks++;
    if (dout !== 4'b0101) begin
      errors++; $display("FAIL ror got %b want 0101", dout);
    end
    mode = 3'b110;
    step();
    checks++;
    if (dout !== 4'b0010) begin
      errors++; $display("FAIL asr_pos got %b want 0010", dout);
    end
    mode = 3'b101;
    step();
    checks++;
    if (dout !== 4'b0100) begin
      errors++; $display("FAIL rol got %b want 0100", dout);
    end
    mode = 3'b011; data_in = 4'b1000;
    step();
    mode = 3'b110;
    step();
    checks++;
    if (dout !== 4'b1100) begin
      errors++; $display("FAIL asr_neg got %b want 1100", dout);
    end
    $display("rotate/asr: dout=%b", dout);
  endtask

  task automatic test_hold_enable();
    mode = 3'b000;
    step();
    checks++;
    if (dout !== 4'b1100) begin
      errors++; $display("FAIL hold got %b want 1100", dout);
    end
    enable = 1'b0; mode = 3'b111;
    step();
    checks++;
    if (dout !== 4'b1100) begin
      errors++; $display("FAIL enable_low got %b want 1100", dout);
    end
    enable = 1'b1; mode = 3'b000;
    $display("hold/enable: dout=%b", dout);
  endtask

  task automatic test_burst3();
    mode = 3'b011; data_in = 4'b1001;
    step();
    burst_start = 1'b1; mode = 3'b101; burst_len = 4'd3;
    step();
    checks++;
    if ({dout, busy, done} !== {4'b0011, 1'b1, 1'b0}) begin
      errors++; $display("FAIL burst3_e1 got %b/%b/%b want 0011/1/0", dout, busy, done);
    end
    burst_start = 1'b0; mode = 3'b111; data_in = 4'b1111;
    step();
    checks++;
    if ({dout, busy, done} !== {4'b0110, 1'b1, 1'b0}) begin
      errors++; $display("FAIL burst3_e2 got %b/%b/%b want 0110/1/0", dout, busy, done);
    end
    mode = 3'b000;
    step();
    checks++;
    if ({dout, busy, done} !== {4'b1100, 1'b0, 1'b1}) begin
      errors++; $display("FAIL burst3_e3 got %b/%b/%b want 1100/0/1", dout, busy, done);
    end
    enable = 1'b0;
    step();
    checks++;
    if ({dout, busy, done} !== {4'b1100, 1'b0, 1'b0}) begin
      errors++; $display("FAIL burst3_doneclr got %b/%b/%b want 1100/0/0", dout, busy, done);
    end
    enable = 1'b1;
    $display("burst3: dout=%b busy=%b done=%b", dout, busy, done);
  endtask

  task automatic test_short_bursts();
    mode = 3'b011; data_in = 4'b0001;
    step();
    burst_start = 1'b1; mode = 3'b010; sin_lsb = 1'b0; burst_len = 4'd1;
    step();
    checks++;
    if ({dout, busy, done} !== {4'b0010, 1'b0, 1'b1}) begin
      errors++; $display("FAIL len1 got %b/%b/%b want 0010/0/1", dout, busy, done);
    end
    mode = 3'b011; data_in = 4'b0110; burst_len = 4'd5;
    step();
    checks++;
    if ({dout, busy, done} !== {4'b0110, 1'b0, 1'b1}) begin
      errors++; $display("FAIL start_load got %b/%b/%b want 0110/0/1", dout, busy, done);
    end
    mode = 3'b001; sin_msb = 1'b0; burst_len = 4'd0;
    step();
    checks++;
    if ({dout, busy, done} !== {4'b0011, 1'b0, 1'b1}) begin
      errors++; $display("FAIL len0 got %b/%b/%b want 0011/0/1", dout, busy, done);
    end
    burst_start = 1'b0; mode = 3'b000;
    step();
    checks++;
    if ({dout, busy, done} !== {4'b0011, 1'b0, 1'b0}) begin
      errors++; $display("FAIL short_idle got %b/%b/%b want 0011/0/0", dout, busy, done);
    end
    $display("short bursts: dout=%b", dout);
  endtask

  task automatic test_stall_reset();
    mode = 3'b011; data_in = 4'b0001;
    step();
    burst_start = 1'b1; mode = 3'b100; burst_len = 4'd5;
    step();
    burst_start = 1'b0; mode = 3'b000;
    checks++;
    if ({dout, busy} !== {4'b1000, 1'b1}) begin
      errors++; $display("FAIL len5_e1 got %b/%b want 1000/1", dout, busy);
    end
    step();
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({dout, busy, done} !== {4'b0100, 1'b1, 1'b0}) begin
        errors++; $display("FAIL stall%0d got %b/%b/%b want 0100/1/0", i, dout, busy, done);
      end
    end
    enable = 1'b1;
    step();
    step();
    checks++;
    if ({dout, busy, done} !== {4'b0001, 1'b1, 1'b0}) begin
      errors++; $display("FAIL len5_e4 got %b/%b/%b want 0001/1/0", dout, busy, done);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout, busy, done} !== {4'b0000, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_rst got %b/%b/%b want 0000/0/0", dout, busy, done);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({dout, busy, done} !== {4'b0000, 1'b0, 1'b0}) begin
        errors++; $display("FAIL post_rst%0d got %b/%b/%b want 0000/0/0", i, dout, busy, done);
      end
    end
    $display("stall/reset: dout=%b busy=%b done=%b", dout, busy, done);
  endtask

  initial begin
    test_reset();
    test_shr();
    test_shl();
    test_rotate_asr();
    test_hold_enable();
    test_burst3();
    test_short_bursts();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
